ser_frame_deserializer: RTL and testbench
=========================================

Name: ser_frame_deserializer

Overview:
- Receive-side stage directly downstream of the serializer: takes the 1-bit serial stream plus bit strobe and rebuilds 8-bit words.
- Finds byte alignment by hunting for a sync word, then delivers fixed-length payload frames as byte strobes.
- Tracks lock with a flywheel: a bounded number of bad sync words is tolerated before re-hunting.

Parameters:
- SYNC_WORD, 8'hF0, frame delimiter, MSB first on the wire
- PAYLOAD_BYTES, 4, data bytes between consecutive sync words (range 1..255)
- LOSS_THRESH, 3, consecutive bad sync words that drop lock (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ser_in  in  1  serial data bit, MSB of each byte first
- ser_valid  in  1  ser_in is sampled only in cycles where this is 1
- out_byte  out  8  recovered payload byte
- out_valid  out  1  one-cycle strobe, out_byte valid
- out_sof  out  1  high with out_valid on the first payload byte of a frame
- locked  out  1  frame alignment held
- sync_err  out  1  one-cycle pulse on each bad sync word while locked

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- Reset values:
  - out_byte=8'h00; out_valid=0; out_sof=0; locked=0; sync_err=0.
  - Shift window=0; state=HUNT; bit_cnt=0; byte_cnt=0; miss_cnt=0.
- Shift window: on ser_valid, win <= {win[6:0], ser_in}. With ser_valid=0, all state holds, no strobes fire, and there is no bit timeout.
- Define nxt = {win[6:0], ser_in}, the window value including the current bit.
- HUNT:
  - Compare nxt==SYNC_WORD on every valid bit.
  - Match: go to DATA with bit_cnt=0, byte_cnt=0, miss_cnt=0; locked=1 from the next cycle.
  - Reset leaves the window at 0. A match therefore needs 8 real bits, unless SYNC_WORD has leading zeros.
- DATA:
  - bit_cnt counts 0..7 on valid bits.
  - On the 8th bit, the next cycle shows out_byte=nxt and out_valid=1. out_sof=1 when byte_cnt==0.
  - byte_cnt increments. After byte PAYLOAD_BYTES, go to CHECK with bit_cnt=0.
  - Latency: strobe exactly 1 clk after the ser_valid cycle carrying the byte's LSB.
- CHECK:
  - Collect 8 valid bits. On the 8th bit, compare nxt with SYNC_WORD.
  - Match: miss_cnt=0, go to DATA, byte_cnt=0.
  - Mismatch: sync_err pulses the next cycle.
    - If miss_cnt+1==LOSS_THRESH: go to HUNT, locked=0 next cycle, miss_cnt=0.
    - Else: miss_cnt++ and go to DATA (flywheel; the payload is still delivered).
  - The sync word itself is never presented on out_byte.
- HUNT re-entry: after lock loss, hunting starts at the next valid bit. The window is not cleared, so overlapping alignments are found.
- Single-cycle events: out_valid and sync_err are mutually exclusive (different states). Each is a pulse, never held for 2 cycles.
- Reset mid-frame: an immediate asynchronous return to the reset values. Any partial byte is discarded and no strobe is emitted.
- Counter widths: bit_cnt 3 b; byte_cnt $clog2(PAYLOAD_BYTES+1); miss_cnt 4 b. No wrap is reachable in legal use.

Decomposition:
- Shared package ser_pkg holds:
  - state enum {HUNT, DATA, CHECK};
  - default SYNC_WORD constant;
  - BYTE_W=8.
- One natural sub-module: ser_shift_window. It holds the 8-bit shift register, the bit counter, and the byte_done flag, and is reusable by the upstream serializer's loopback checker.
- The FSM and the lock/flywheel counter stay in the top module.

Test Plan:
- Clean lock: reset 5 cycles, then send bits F0 A5 3C 01 FF F0 11 22 33 44 with ser_valid=1 continuously. Required response:
  - out_valid 4 times per frame;
  - bytes A5 3C 01 FF then 11 22 33 44;
  - out_sof on A5 and 11; locked=1 from the cycle after the first F0 completes; sync_err never.
- Misaligned start: prefix 3 garbage bits 101 before the first F0. Required response: same bytes, no strobes before lock.
- Gapped strobe: same stream, ser_valid toggling 1/0. Required response: identical byte sequence; each strobe 1 clk after its LSB's valid cycle.
- Flywheel: locked, then replace 2 consecutive sync words with 0x00. Required response:
  - sync_err pulses twice; locked stays 1;
  - payloads are still delivered; the third good F0 clears miss_cnt.
- Lock loss: 3 consecutive bad syncs (LOSS_THRESH=3). Required response: locked falls 1 clk after the 3rd bad sync; no out_valid until the next F0 is found in HUNT.
- Reset mid-byte: assert reset after 4 payload bits. Required response: all outputs 0 asynchronously; no partial-byte strobe; relock on the next F0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial frame receive path.
package ser_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hF0;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } state_t;
endpackage

// File: rtl/ser_shift_window.sv
// 8-bit serial shift window with a bit counter; flags the 8th valid bit of each byte.
module ser_shift_window
  import ser_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_valid,
  input  logic              ser_in,
  input  logic              bit_clr,
  output logic [BYTE_W-1:0] nxt,
  output logic              byte_done
);
  logic [BYTE_W-1:0] win_reg;
  logic [2:0]        bit_cnt_reg;

  // nxt already includes the bit being presented this cycle
  assign nxt       = {win_reg[BYTE_W-2:0], ser_in};
  assign byte_done = ser_valid && !bit_clr && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_reg     <= '0;
      bit_cnt_reg <= '0;
    end else if (ser_valid) begin
      win_reg     <= nxt;
      bit_cnt_reg <= bit_clr ? 3'd0 : bit_cnt_reg + 3'd1;
    end
  end
endmodule

// File: rtl/ser_frame_deserializer.sv
// Sync-word framed deserializer: hunts for alignment, emits payload bytes, flywheel lock tracking.
module ser_frame_deserializer
  import ser_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         LOSS_THRESH   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_sof,
  output logic       locked,
  output logic       sync_err
);
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(PAYLOAD_BYTES - 1);
  localparam logic [3:0]    LAST_MISS = 4'(LOSS_THRESH - 1);

  state_t      state_reg, state_next;
  logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [3:0]  miss_cnt_reg, miss_cnt_next;
  logic [7:0]  out_byte_reg, out_byte_next;
  logic        out_valid_reg, out_valid_next;
  logic        out_sof_reg, out_sof_next;
  logic        sync_err_reg, sync_err_next;
  logic [7:0]  nxt;
  logic        byte_done;

  // While hunting the bit counter is pinned at 0 so DATA starts byte-aligned
  ser_shift_window u_win (
    .clk       (clk),
    .reset     (reset),
    .ser_valid (ser_valid),
    .ser_in    (ser_in),
    .bit_clr   (state_reg == HUNT),
    .nxt       (nxt),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= HUNT;
      byte_cnt_reg  <= '0;
      miss_cnt_reg  <= '0;
      out_byte_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      out_byte_reg  <= out_byte_next;
      out_valid_reg <= out_valid_next;
      out_sof_reg   <= out_sof_next;
      sync_err_reg  <= sync_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    out_byte_next  = out_byte_reg;
    out_valid_next = 1'b0;
    out_sof_next   = 1'b0;
    sync_err_next  = 1'b0;
    case (state_reg)
      HUNT: begin
        if (ser_valid && nxt == SYNC_WORD) begin
          state_next    = DATA;
          byte_cnt_next = '0;
          miss_cnt_next = '0;
        end
      end
      DATA: begin
        if (byte_done) begin
          out_byte_next  = nxt;
          out_valid_next = 1'b1;
          out_sof_next   = (byte_cnt_reg == '0);
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next    = CHECK;
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end
      CHECK: begin
        if (byte_done) begin
          byte_cnt_next = '0;
          if (nxt == SYNC_WORD) begin
            miss_cnt_next = '0;
            state_next    = DATA;
          end else begin
            sync_err_next = 1'b1;
            // Flywheel: tolerate misses until the threshold, then re-hunt
            if (miss_cnt_reg == LAST_MISS) begin
              miss_cnt_next = '0;
              state_next    = HUNT;
            end else begin
              miss_cnt_next = miss_cnt_reg + 4'd1;
              state_next    = DATA;
            end
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign out_byte  = out_byte_reg;
  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign sync_err  = sync_err_reg;
  assign locked    = (state_reg != HUNT);
endmodule

// File: tb/tb_ser_frame_deserializer.sv
// Self-checking bench: frame-position reference model compared every cycle, plus literal scenario checks.
module tb_ser_frame_deserializer;
  localparam int P  = 4;
  localparam int LT = 3;
  localparam logic [7:0] SW = 8'hF0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid, out_sof, locked, sync_err;

  int errors = 0;
  int checks = 0;
  int gap_mode = 0;
  logic [7:0] cap[$];
  int n_err = 0;
  int n_sof = 0;

  ser_frame_deserializer #(.SYNC_WORD(SW), .PAYLOAD_BYTES(P), .LOSS_THRESH(LT)) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .out_byte(out_byte), .out_valid(out_valid), .out_sof(out_sof),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a single bit position within the (P+1)-byte frame period
  bit         m_lock = 0;
  int         m_pos = 0;
  int         m_miss = 0;
  logic [7:0] m_win = 8'h00;
  logic [7:0] m_n;
  int         m_idx;
  logic [7:0] e_byte = 8'h00;
  bit         e_valid = 0, e_sof = 0, e_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lock = 0; m_pos = 0; m_miss = 0; m_win = 8'h00;
      e_byte = 8'h00; e_valid = 0; e_sof = 0; e_err = 0;
    end else begin
      e_valid = 0; e_sof = 0; e_err = 0;
      if (ser_valid) begin
        m_n = {m_win[6:0], ser_in};
        m_win = m_n;
        if (!m_lock) begin
          if (m_n == SW) begin
            m_lock = 1; m_pos = 0; m_miss = 0;
          end
        end else begin
          if (m_pos % 8 == 7) begin
            m_idx = m_pos / 8;
            if (m_idx < P) begin
              e_valid = 1; e_byte = m_n; e_sof = (m_idx == 0);
            end else if (m_n == SW) begin
              m_miss = 0;
            end else begin
              e_err = 1;
              m_miss++;
              if (m_miss == LT) begin
                m_lock = 0; m_miss = 0;
              end
            end
          end
          m_pos = (m_pos + 1) % ((P + 1) * 8);
        end
      end
    end
  end

  // Per-cycle compare against the model, plus capture for literal checks
  always @(negedge clk) begin
    chk("locked", locked, m_lock);
    chk("out_valid", out_valid, e_valid);
    chk("out_sof", out_sof, e_sof);
    chk("sync_err", sync_err, e_err);
    if (e_valid || reset) chk("out_byte", out_byte, e_byte);
    if (out_valid) cap.push_back(out_byte);
    if (sync_err) n_err++;
    if (out_sof) n_sof++;
  end

  task automatic drive(input logic v, input logic d);
    @(posedge clk);
    #1;
    ser_valid = v;
    ser_in = d;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b);
    if (gap_mode == 1) drive(1'b0, 1'($urandom));
    if (gap_mode == 2) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] base);
    send_byte(s);
    for (int k = 0; k < P; k++) send_byte(base + 8'(k));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1; ser_valid = 1'b0; ser_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    cap.delete(); n_err = 0; n_sof = 0;
  endtask

  task automatic chk_cap(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk({name, "_byte"}, cap[i], exp[i]);
  endtask

  initial begin
    logic [7:0] exp[$];

    // Clean lock
    reset_dut();
    chk("reset_out_byte", out_byte, 8'h00);
    chk("reset_locked", locked, 1'b0);
    gap_mode = 0;
    send_byte(8'hF0); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'hF0); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    exp = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    chk_cap("clean", exp);
    chk("clean_sof", n_sof, 2);
    chk("clean_err", n_err, 0);

    // Misaligned start
    reset_dut();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hF0); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'hF0); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    chk_cap("misalign", exp);

    // Gapped strobe
    reset_dut();
    gap_mode = 1;
    send_byte(8'hF0); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'hF0); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    chk_cap("gapped", exp);
    gap_mode = 0;

    // Flywheel: two bad, good, two bad -> lock held throughout
    reset_dut();
    send_frame(8'hF0, 8'h10); send_frame(8'h00, 8'h20); send_frame(8'h00, 8'h30);
    send_frame(8'hF0, 8'h40); send_frame(8'h00, 8'h50); send_frame(8'h00, 8'h60);
    idle(3);
    chk("fly_err", n_err, 4);
    chk("fly_locked", locked, 1'b1);
    chk("fly_count", cap.size(), 6 * P);

    // Lock loss after three bad syncs, relock on next sync
    reset_dut();
    send_frame(8'hF0, 8'h10); send_frame(8'h00, 8'h20); send_frame(8'h00, 8'h30);
    send_byte(8'h00);
    idle(2);
    chk("loss_locked", locked, 1'b0);
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    send_frame(8'hF0, 8'h70);
    idle(3);
    chk("loss_err", n_err, 3);
    chk("loss_count", cap.size(), 4 * P);
    if (cap.size() == 4 * P) chk("loss_relock_byte", cap[3 * P], 8'h70);

    // Reset mid-byte
    reset_dut();
    send_byte(8'hF0); send_byte(8'hA5);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("pre_reset_locked", locked, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1; ser_valid = 1'b0;
    #1;
    chk("async_locked", locked, 1'b0);
    chk("async_valid", out_valid, 1'b0);
    chk("async_byte", out_byte, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(8'hF0, 8'h11);
    idle(3);
    exp = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h14};
    chk_cap("midreset", exp);

    // Randomized frames with gaps and corrupted syncs
    reset_dut();
    gap_mode = 2;
    repeat ($urandom_range(0, 7)) send_bit(1'($urandom));
    for (int f = 0; f < 80; f++) begin
      send_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : SW);
      for (int k = 0; k < P; k++) send_byte(8'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
